// File: rtl/microcode_pkg.sv
// rtl/microcode_pkg.sv - branch-control codes and microword field positions for microcode_sequencer
package microcode_pkg;

    localparam int CTRL_W = 3;

    typedef enum logic [CTRL_W-1:0] {
        SEQ   = 3'd0,
        DISP0 = 3'd1,
        DISP1 = 3'd2,
        JMP   = 3'd3,
        BR    = 3'd4,
        CALL  = 3'd5,
        RET   = 3'd6,
        HALT  = 3'd7
    } ctrl_e;

    // Microword layout, MSB first: {ctrl, target, uop}
    function automatic int word_w(input int state_w, input int out_w);
        return CTRL_W + state_w + out_w;
    endfunction

    function automatic int ctrl_lsb(input int state_w, input int out_w);
        return state_w + out_w;
    endfunction

    function automatic int target_lsb(input int out_w);
        return out_w;
    endfunction

endpackage

// File: rtl/micro_stack.sv
// rtl/micro_stack.sv - return-address LIFO with synchronously reset stack pointer
module micro_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               push_data,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     sp
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp_m1;

    assign full     = (sp == SP_W'(DEPTH));
    assign empty    = (sp == '0);
    assign sp_m1    = sp - SP_W'(1);
    assign pop_data = mem[sp_m1[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    // Entries are never cleared; only the pointer decides what is live.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcoded state sequencer with writeable control store and dispatch tables
module microcode_sequencer
    import microcode_pkg::*;
#(
    parameter int STATE_W     = 4,
    parameter int IN_W        = 2,
    parameter int OUT_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [IN_W-1:0]               in,
    input  logic                          cs_we,
    input  logic [STATE_W-1:0]            cs_addr,
    input  logic [3+STATE_W+OUT_W-1:0]    cs_wdata,
    input  logic                          dt_we,
    input  logic                          dt_sel,
    input  logic [IN_W-1:0]               dt_idx,
    input  logic [STATE_W-1:0]            dt_wdata,
    output logic [STATE_W-1:0]            state,
    output logic [OUT_W-1:0]              uop,
    output logic                          halted,
    output logic                          err
);

    localparam int WORD_W   = word_w(STATE_W, OUT_W);
    localparam int CS_N     = 2 ** STATE_W;
    localparam int DT_N     = 2 ** IN_W;
    localparam int SP_W     = $clog2(STACK_DEPTH) + 1;
    localparam int BR_W     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int CTRL_LSB = ctrl_lsb(STATE_W, OUT_W);
    localparam int TGT_LSB  = target_lsb(OUT_W);

    logic [WORD_W-1:0]  cs_mem [CS_N];
    logic [STATE_W-1:0] dt0    [DT_N];
    logic [STATE_W-1:0] dt1    [DT_N];

    logic [WORD_W-1:0]  cur;
    ctrl_e              ctrl;
    logic [STATE_W-1:0] target;
    logic [STATE_W-1:0] state_inc;
    logic [BR_W-1:0]    br_idx;
    logic               br_taken;

    logic [STATE_W-1:0] next_state;
    logic               push;
    logic               pop;
    logic               set_err;
    logic               stack_push;
    logic               stack_pop;
    logic [STATE_W-1:0] pop_data;
    logic               full;
    logic               empty;
    logic [SP_W-1:0]    sp;

    assign cur       = cs_mem[state];
    assign ctrl      = ctrl_e'(cur[CTRL_LSB +: CTRL_W]);
    assign target    = cur[TGT_LSB +: STATE_W];
    assign uop       = cur[OUT_W-1:0];
    assign halted    = (ctrl == HALT);
    assign state_inc = state + STATE_W'(1);
    assign br_idx    = target[BR_W-1:0];
    assign br_taken  = in[br_idx];

    always_comb begin
        next_state = state;
        push       = 1'b0;
        pop        = 1'b0;
        set_err    = 1'b0;
        case (ctrl)
            SEQ:   next_state = state_inc;
            DISP0: next_state = dt0[in];
            DISP1: next_state = dt1[in];
            JMP:   next_state = target;
            BR:    next_state = br_taken ? target : state_inc;
            CALL: begin
                if (!full) begin
                    push       = 1'b1;
                    next_state = target;
                end else begin
                    set_err = 1'b1;
                end
            end
            RET: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = pop_data;
                end else begin
                    set_err = 1'b1;
                end
            end
            default: next_state = state;
        endcase
    end

    assign stack_push = push && !stall;
    assign stack_pop  = pop && !stall;

    micro_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (STATE_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (state_inc),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .sp        (sp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
            err   <= 1'b0;
        end else if (!stall) begin
            state <= next_state;
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    // Store writes land at the edge, so the decision above always sees the old word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (cs_we) begin
                cs_mem[cs_addr] <= cs_wdata;
            end
            if (dt_we) begin
                if (dt_sel) begin
                    dt1[dt_idx] <= dt_wdata;
                end else begin
                    dt0[dt_idx] <= dt_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed table-driven bench for microcode_sequencer
module tb_microcode_sequencer;
    import microcode_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  in_v = '0;
    logic        cs_we = 1'b0;
    logic [3:0]  cs_addr = '0;
    logic [14:0] cs_wdata = '0;
    logic        dt_we = 1'b0;
    logic        dt_sel = 1'b0;
    logic [1:0]  dt_idx = '0;
    logic [3:0]  dt_wdata = '0;
    logic [3:0]  state;
    logic [7:0]  uop;
    logic        halted;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       stall;
        logic [1:0] in;
        int         exp_state;
        int         exp_sp;
        int         exp_halted;
        int         exp_err;
    } vec_t;

    vec_t vq[$];

    microcode_sequencer #(
        .STATE_W     (4),
        .IN_W        (2),
        .OUT_W       (8),
        .STACK_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .in       (in_v),
        .cs_we    (cs_we),
        .cs_addr  (cs_addr),
        .cs_wdata (cs_wdata),
        .dt_we    (dt_we),
        .dt_sel   (dt_sel),
        .dt_idx   (dt_idx),
        .dt_wdata (dt_wdata),
        .state    (state),
        .uop      (uop),
        .halted   (halted),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] uop_of(input logic [3:0] a);
        return {a, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic chk_all(input string tag, input int es, input int esp, input int eh, input int ee);
        chk({tag, ".state"},  int'(state),  es);
        chk({tag, ".uop"},    int'(uop),    int'(uop_of(4'(es))));
        chk({tag, ".sp"},     int'(dut.sp), esp);
        chk({tag, ".halted"}, int'(halted), eh);
        chk({tag, ".err"},    int'(err),    ee);
    endtask

    task automatic wr_cs(input logic [3:0] a, input ctrl_e c, input logic [3:0] t);
        cs_we    = 1'b1;
        cs_addr  = a;
        cs_wdata = {c, t, uop_of(a)};
        step();
        cs_we    = 1'b0;
    endtask

    task automatic wr_dt(input logic sel, input logic [1:0] idx, input logic [3:0] v);
        dt_we    = 1'b1;
        dt_sel   = sel;
        dt_idx   = idx;
        dt_wdata = v;
        step();
        dt_we    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
    endtask

    task automatic add(input logic s, input logic [1:0] i, input int es, input int esp,
                       input int eh, input int ee);
        vec_t v;
        v.stall = s; v.in = i; v.exp_state = es; v.exp_sp = esp;
        v.exp_halted = eh; v.exp_err = ee;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            stall = vq[i].stall;
            in_v  = vq[i].in;
            step();
            chk_all($sformatf("%s[%0d]", tag, i), vq[i].exp_state, vq[i].exp_sp,
                    vq[i].exp_halted, vq[i].exp_err);
        end
        vq.delete();
        stall = 1'b0;
    endtask

    initial begin
        do_reset();
        stall = 1'b1;
        for (int a = 0; a < 16; a++) wr_cs(4'(a), SEQ, 4'd0);

        // SEQ run into HALT
        wr_cs(4'd4, HALT, 4'd0);
        do_reset();
        chk_all("reset", 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0); add(0, 0, 2, 0, 0, 0); add(0, 0, 3, 0, 0, 0);
        add(0, 0, 4, 0, 1, 0); add(0, 0, 4, 0, 1, 0); add(0, 0, 4, 0, 1, 0);
        run_vecs("seq");

        // dispatch tables
        stall = 1'b1;
        wr_dt(0, 2'd0, 4'd5); wr_dt(0, 2'd1, 4'd9); wr_dt(0, 2'd2, 4'd12); wr_dt(0, 2'd3, 4'd3);
        wr_dt(1, 2'd3, 4'd6);
        wr_cs(4'd0, DISP0, 4'd0);
        do_reset();
        add(0, 2'b10, 12, 0, 0, 0); run_vecs("disp0_in2");
        do_reset();
        add(0, 2'b01, 9, 0, 0, 0); run_vecs("disp0_in1");
        reset = 1'b1; dt_we = 1'b1; dt_sel = 1'b0; dt_idx = 2'd2; dt_wdata = 4'd1;
        cs_we = 1'b1; cs_addr = 4'd0; cs_wdata = {HALT, 4'd0, 8'h00};
        step();
        reset = 1'b0; dt_we = 1'b0; cs_we = 1'b0;
        add(0, 2'b10, 12, 0, 0, 0); run_vecs("wr_in_reset");
        stall = 1'b1;
        wr_cs(4'd0, DISP1, 4'd0);
        do_reset();
        add(0, 2'b11, 6, 0, 0, 0); run_vecs("disp1");

        // CALL / RET
        stall = 1'b1;
        wr_cs(4'd0, SEQ, 4'd0); wr_cs(4'd2, CALL, 4'd8);
        wr_cs(4'd8, RET, 4'd0); wr_cs(4'd3, HALT, 4'd0);
        do_reset();
        add(0, 0, 1, 0, 0, 0); add(0, 0, 2, 0, 0, 0); add(0, 0, 8, 1, 0, 0);
        add(0, 0, 3, 0, 1, 0); add(0, 0, 3, 0, 1, 0);
        run_vecs("callret");

        // overflow, stall on CALL, reset mid-chain
        stall = 1'b1;
        wr_cs(4'd0, JMP, 4'd5); wr_cs(4'd5, CALL, 4'd5);
        do_reset();
        add(0, 0, 5, 0, 0, 0); add(0, 0, 5, 1, 0, 0); add(0, 0, 5, 2, 0, 0);
        add(1, 0, 5, 2, 0, 0); add(0, 0, 5, 3, 0, 0); add(0, 0, 5, 4, 0, 0);
        add(0, 0, 5, 4, 0, 1); add(0, 0, 5, 4, 0, 1);
        run_vecs("overflow");
        do_reset();
        chk_all("rst_after_err", 0, 0, 0, 0);
        add(0, 0, 5, 0, 0, 0); add(0, 0, 5, 1, 0, 0); add(0, 0, 5, 2, 0, 0);
        run_vecs("chain");
        do_reset();
        chk_all("rst_mid_chain", 0, 0, 0, 0);
        add(0, 0, 5, 0, 0, 0); add(0, 0, 5, 1, 0, 0);
        run_vecs("store_intact");

        // RET on empty stack
        stall = 1'b1;
        wr_cs(4'd0, RET, 4'd0);
        do_reset();
        add(0, 0, 0, 0, 0, 1); add(0, 0, 0, 0, 0, 1);
        run_vecs("underflow");

        // stall mid-SEQ
        stall = 1'b1;
        for (int a = 0; a < 4; a++) wr_cs(4'(a), SEQ, 4'd0);
        wr_cs(4'd4, HALT, 4'd0);
        do_reset();
        add(0, 0, 1, 0, 0, 0); add(0, 0, 2, 0, 0, 0);
        add(1, 0, 2, 0, 0, 0); add(1, 0, 2, 0, 0, 0); add(1, 0, 2, 0, 0, 0);
        add(0, 0, 3, 0, 0, 0); add(0, 0, 4, 0, 1, 0);
        run_vecs("stall");

        // conditional branch: target bit 0 selects the input bit
        stall = 1'b1;
        wr_cs(4'd0, BR, 4'd6);
        do_reset(); add(0, 2'b01, 6, 0, 0, 0); run_vecs("br6_taken");
        do_reset(); add(0, 2'b10, 1, 0, 0, 0); run_vecs("br6_not");
        stall = 1'b1;
        wr_cs(4'd0, BR, 4'd5);
        do_reset(); add(0, 2'b10, 5, 0, 0, 0); run_vecs("br5_taken");
        do_reset(); add(0, 2'b01, 1, 0, 0, 0); run_vecs("br5_not");

        // wrap 15 -> 0 and same-cycle write of the executing word
        stall = 1'b1;
        wr_cs(4'd0, JMP, 4'd15); wr_cs(4'd15, SEQ, 4'd0);
        do_reset();
        add(0, 0, 15, 0, 0, 0); add(0, 0, 0, 0, 0, 0); add(0, 0, 15, 0, 0, 0);
        run_vecs("wrap");
        cs_we = 1'b1; cs_addr = 4'd15; cs_wdata = {JMP, 4'd7, uop_of(4'd15)};
        step();
        cs_we = 1'b0;
        chk("same_cycle_wr.state", int'(state), 0);
        step();
        chk("revisit15.state", int'(state), 15);
        step();
        chk("jmp7.state", int'(state), 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised microcoded state sequencer: the generalised successor of the fixed 4-bit, 2-input microcode FSM.
- A writeable control store supplies, for each state, a branch-control code, a branch target and a micro-op output field.
- Next-state logic supports sequential, dispatch, jump, conditional, call/return and halt.
- Sits between the control-store loader and downstream datapath control; one instance per controller.

Parameters:
- STATE_W, 4: state/address width; control store has 2**STATE_W words.
- IN_W, 2: width of the condition/dispatch input `in`; each dispatch table has 2**IN_W entries.
- OUT_W, 8: width of the micro-op output field.
- STACK_DEPTH, 4: return-stack entries, power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  when high, sequencer state and stack hold.
- in  in  IN_W  condition/dispatch input.
- cs_we  in  1  control-store write enable.
- cs_addr  in  STATE_W  control-store write address.
- cs_wdata  in  3+STATE_W+OUT_W  microword {ctrl[2:0], target, uop}.
- dt_we  in  1  dispatch-table write enable.
- dt_sel  in  1  dispatch table select (0/1).
- dt_idx  in  IN_W  dispatch-table entry index.
- dt_wdata  in  STATE_W  dispatch-table entry value.
- state  out  STATE_W  current state.
- uop  out  OUT_W  uop field of control_store[state]; combinational from state.
- halted  out  1  high while the current word is HALT.
- err  out  1  sticky stack-error flag.

Behaviour:
- Reset (sync, highest priority):
  - state=0, sp=0, err=0.
  - Control store and dispatch tables are not cleared.
  - cs_we/dt_we asserted in a reset cycle are ignored.
- Word fetch:
  - cur = control_store[state]; ctrl = cur[top 3 bits].
  - halted = (ctrl==HALT), combinational.
- Next state when not stall and not reset (1-cycle latency):
  - 0 SEQ: state+1, mod 2**STATE_W (wraps to 0).
  - 1 DISP0: dispatch0[in].
  - 2 DISP1: dispatch1[in].
  - 3 JMP: target.
  - 4 BR: `target` if in[target[$clog2(IN_W)-1:0]]==1, else state+1.
  - 5 CALL:
    - stack not full: push state+1, sp++, go to target.
    - stack full: state holds, err<=1.
  - 6 RET:
    - stack not empty: sp--, go to popped value.
    - stack empty: state holds, err<=1.
  - 7 HALT: state holds; leaving HALT only via reset.
- stall=1: state, sp and stack unchanged; err unchanged. Writes still occur.
- Writes:
  - cs_we and dt_we are independent and may both occur in one cycle.
  - Each takes effect at the clock edge, visible from the next cycle.
  - A write to control_store[state] in the same cycle is not seen by that cycle's next-state decision, which uses the old word.
- err is cleared only by reset. The stack still operates after err is set.
- Width rules:
  - state+1 is truncated to STATE_W.
  - sp is $clog2(STACK_DEPTH)+1 bits; full means sp==STACK_DEPTH.

Decomposition:
- Package microcode_pkg holds:
  - ctrl enum: SEQ, DISP0, DISP1, JMP, BR, CALL, RET, HALT = 0..7.
  - Microword field-position helpers.
- One sub-module, micro_stack: sync LIFO with push/pop/full/empty and a synchronous reset of its pointer.
- Control store, dispatch tables and next-state mux stay in the top module.

Test Plan:
- Load words 0..3 as SEQ, word 4 as HALT; reset; run -> state 0,1,2,3,4 then holds at 4 with halted=1; uop tracks the loaded values.
- dispatch0 = {5,9,12,3}, word 0 = DISP0, in=2'b10 -> state 12 one cycle after reset release; repeat with in=2'b01 -> state 9.
- Word 2 = CALL target 8; word 8 = RET -> sequence 0,1,2,8,3; sp returns to 0; err=0.
- STACK_DEPTH=4, word 5 = CALL target 5 -> sp reaches 4; fifth CALL holds state at 5 with err=1. Word 0 = RET after reset -> state stays 0, err=1.
- Assert stall for 3 cycles mid-SEQ at state 2 -> state holds at 2, then resumes at 3. Assert reset mid-CALL-chain -> state 0, sp 0, err 0, store contents intact.
- STATE_W=4, word 15 = SEQ -> state wraps 15 to 0. Write word[state] to JMP 7 in the same cycle as executing SEQ -> next state is state+1; the JMP applies on a later visit.
